gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 86 ++++++++
 tb/tb_gray_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down counter holding a binary count and a registered Gray image of it.
// Gray loads are converted back to binary internally; WRAP selects wrap-around or saturation.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] binary_out,
    output logic             limit_pulse
);

    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] ONE_CNT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_limit;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_limit;
    logic             w_acc;

    // Gray-to-binary as an XOR prefix chain from the MSB down.
    always_comb begin
        w_acc      = 1'b0;
        w_load_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_acc         = w_acc ^ load_gray[i];
            w_load_bin[i] = w_acc;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_bin   = r_bin;
        w_next_limit = 1'b0;
        if (load) begin
            w_next_bin = w_load_bin;
        end else if (en) begin
            if (up) begin
                if (r_bin == MAX_CNT) begin
                    w_next_limit = 1'b1;
                    w_next_bin   = WRAP ? '0 : r_bin;
                end else begin
                    w_next_bin = r_bin + ONE_CNT;
                end
            end else begin
                if (r_bin == '0) begin
                    w_next_limit = 1'b1;
                    w_next_bin   = WRAP ? MAX_CNT : r_bin;
                end else begin
                    w_next_bin = r_bin - ONE_CNT;
                end
            end
        end
        // A load takes the Gray value verbatim; it equals the re-encoded binary anyway.
        w_next_gray = load ? load_gray : (w_next_bin ^ (w_next_bin >> 1));
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_limit <= 1'b0;
        end else begin
            r_bin   <= w_next_bin;
            r_gray  <= w_next_gray;
            r_limit <= w_next_limit;
        end
    end

    assign gray_out    = r_gray;
    assign binary_out  = r_bin;
    assign limit_pulse = r_limit;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// share one stimulus stream; a reference model pushes expectations that are popped after each edge.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_gray;

    logic [3:0] g_w4, b_w4;
    logic [3:0] g_s4, b_s4;
    logic [7:0] g_w8, b_w8;
    logic       l_w4, l_s4, l_w8;

    int n_vec = 0;
    int n_err = 0;

    int         widths[3] = '{4, 4, 8};
    bit         wraps[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] m_bin[3];
    logic [7:0] last_gray[3];

    logic [7:0] a_bin[3];
    logic [7:0] a_gray[3];
    logic       a_lim[3];

    typedef struct packed {
        logic [2:0][7:0] bin;
        logic [2:0][7:0] prev;
        logic [2:0]      lim;
        logic            ld;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray[3:0]),
        .gray_out(g_w4), .binary_out(b_w4), .limit_pulse(l_w4)
    );

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray[3:0]),
        .gray_out(g_s4), .binary_out(b_s4), .limit_pulse(l_s4)
    );

    gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray_out(g_w8), .binary_out(b_w8), .limit_pulse(l_w8)
    );

    assign a_bin[0]  = {4'b0, b_w4};
    assign a_bin[1]  = {4'b0, b_s4};
    assign a_bin[2]  = b_w8;
    assign a_gray[0] = {4'b0, g_w4};
    assign a_gray[1] = {4'b0, g_s4};
    assign a_gray[2] = g_w8;
    assign a_lim[0]  = l_w4;
    assign a_lim[1]  = l_s4;
    assign a_lim[2]  = l_w8;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference step; Gray decode here is the XOR of all right shifts of the code.
    function automatic void model_step(input int w, input bit wrap, input logic [7:0] b,
                                       input logic e, input logic u, input logic ld,
                                       input logic [7:0] g,
                                       output logic [7:0] nb, output logic lim);
        logic [7:0] mask;
        logic [7:0] gm;
        mask = 8'hFF >> (8 - w);
        nb   = b;
        lim  = 1'b0;
        if (ld) begin
            gm = g & mask;
            nb = 8'h00;
            for (int s = 0; s < 8; s++) nb = nb ^ (gm >> s);
        end else if (e) begin
            if (u) begin
                if (b == mask) begin
                    lim = 1'b1;
                    nb  = wrap ? 8'h00 : b;
                end else begin
                    nb = b + 8'h01;
                end
            end else begin
                if (b == 8'h00) begin
                    lim = 1'b1;
                    nb  = wrap ? mask : b;
                end else begin
                    nb = b - 8'h01;
                end
            end
        end
    endfunction

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_bin[%0d]", tag, i), a_bin[i], 0);
            check($sformatf("%s_gray[%0d]", tag, i), a_gray[i], 0);
            check($sformatf("%s_lim[%0d]", tag, i), a_lim[i], 0);
            m_bin[i]     = 8'h00;
            last_gray[i] = 8'h00;
        end
    endtask

    task automatic sample();
        exp_t       x;
        logic [7:0] eg;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            x = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                eg = x.bin[i] ^ (x.bin[i] >> 1);
                check($sformatf("bin[%0d]", i), a_bin[i], x.bin[i]);
                check($sformatf("gray[%0d]", i), a_gray[i], eg);
                check($sformatf("lim[%0d]", i), a_lim[i], x.lim[i]);
                if (!x.ld)
                    check($sformatf("hamming[%0d]", i), $countones(a_gray[i] ^ last_gray[i]),
                          (x.bin[i] != x.prev[i]) ? 1 : 0);
                last_gray[i] = a_gray[i];
            end
        end
    endtask

    task automatic step(input logic e, input logic u, input logic ld, input logic [7:0] g);
        exp_t       x;
        logic [7:0] nb;
        logic       lm;
        en        = e;
        up        = u;
        load      = ld;
        load_gray = g;
        x         = '0;
        x.ld      = ld;
        for (int i = 0; i < 3; i++) begin
            model_step(widths[i], wraps[i], m_bin[i], e, u, ld, g, nb, lm);
            x.prev[i] = m_bin[i];
            x.bin[i]  = nb;
            x.lim[i]  = lm;
            m_bin[i]  = nb;
        end
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        up        = 1'b0;
        load      = 1'b0;
        load_gray = 8'h00;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);

        // Full up-count: 4-bit wrap crosses 15->0, saturating copy pins at 15.
        repeat (17) step(1'b1, 1'b1, 1'b0, 8'h00);

        // Down from zero.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);

        // Saturation attempts repeat, then reverse direction.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (18) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Load wins over a simultaneous count, then counting resumes from the loaded value.
        step(1'b1, 1'b1, 1'b1, 8'h0D);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 8'h00);

        // Mixed traffic with direction flips and occasional loads.
        repeat (80) step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                         ($urandom_range(0, 7) == 0), 8'($urandom));

        // Async reset between edges at count 7.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (7) step(1'b1, 1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        #3;
        rst = 1'b0;

        // Long up-run: 8-bit copy wraps 255->0.
        repeat (257) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
